calc_op_sequencer: RTL and testbench

Multi-cycle controller and datapath sequencer for the calculator's arithmetic functions on two WIDTH-bit unsigned operands. It accepts one command at a time over a valid/ready handshake and runs it on a single shared adder/subtractor. Multiply is iterative shift-add; divide is iterative restoring division. It also chains these for the composite RATIO function (a*b)/(a+b). The result is returned over a valid/ready response channel. The block sits between the keypad/command front end and the display formatter.

---
 rtl/calc_op_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// ---------------------------------------------------------------------------
// calc_op_sequencer
//
// Multi-cycle arithmetic sequencer for the calculator. It accepts one command
// at a time and runs it on a single shared adder/subtractor:
//   ADD / SUB : one ADD-state cycle
//   MUL       : WIDTH iterations of shift-add
//   DIV       : 2*WIDTH iterations of restoring division
//   RATIO     : MUL (a*b), then ADD (a+b), then DIV (product / sum)
// Divide-by-zero and illegal opcodes return rsp_err=1.
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready   : command handshake; cmd_op, cmd_a, cmd_b captured
//                           on acceptance
//   rsp_valid/rsp_ready   : response handshake; rsp_result, rsp_residue,
//                           rsp_err are held stable while rsp_valid is high
//   busy                  : high whenever the sequencer is not idle
// All outputs are registered.
// ---------------------------------------------------------------------------
module calc_op_sequencer #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic [2*WIDTH-1:0]   rsp_residue,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(RW);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_RATIO = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [RW-1:0]    r_acc;     // product accumulator
  logic [RW-1:0]    r_mcand;   // multiplicand, shifted left each MUL cycle
  logic [WIDTH-1:0] r_mplier;  // multiplier, shifted right each MUL cycle
  logic [RW-1:0]    r_rem;     // partial remainder
  logic [RW-1:0]    r_quo;     // dividend shifting out, quotient shifting in
  logic [RW-1:0]    r_dvs;     // divisor
  logic [CW-1:0]    r_cnt;     // iteration counter within MUL / DIV

  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [RW-1:0]    r_res;
  logic [RW-1:0]    r_resid;
  logic             r_err;
  logic             r_busy;

  // Shared adder/subtractor
  logic [RW-1:0]    w_add_x;
  logic [RW-1:0]    w_add_y;
  logic             w_add_sub;
  logic [RW:0]      w_sum;

  logic             w_accept;
  logic             w_ratio;
  logic             w_last_mul;
  logic             w_last_div;
  logic             w_div_zero;
  logic [RW-1:0]    w_div_x;
  logic             w_div_ge;
  logic [RW-1:0]    w_rem_next;
  logic [RW-1:0]    w_quo_next;
  logic [RW-1:0]    w_mul_acc;

  assign w_accept   = cmd_valid && r_cmd_ready;
  assign w_ratio    = (r_op == OP_RATIO);
  assign w_last_mul = (r_cnt == CW'(WIDTH - 1));
  assign w_last_div = (r_cnt == CW'(RW - 1));
  // The divisor is only inspected before the first iteration has run.
  assign w_div_zero = (r_cnt == '0) && (r_dvs == '0);

  // Subtraction is x + ~y + 1; the carry out is set exactly when x >= y,
  // which is the "non-negative" test of restoring division.
  assign w_sum = {1'b0, w_add_x} + {1'b0, (w_add_y ^ {RW{w_add_sub}})}
               + {{RW{1'b0}}, w_add_sub};

  // Remainder stays below the divisor (at most 2*(2^WIDTH-1)), so shifting it
  // left by one never overflows RW bits.
  assign w_div_x    = {r_rem[RW-2:0], r_quo[RW-1]};
  assign w_div_ge   = w_sum[RW];
  assign w_rem_next = w_div_ge ? w_sum[RW-1:0] : w_div_x;
  assign w_quo_next = {r_quo[RW-2:0], w_div_ge};
  assign w_mul_acc  = r_mplier[0] ? w_sum[RW-1:0] : r_acc;

  always_comb begin
    w_next    = r_state;
    w_add_x   = '0;
    w_add_y   = '0;
    w_add_sub = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_ADD, OP_SUB:   w_next = S_ADD;
            OP_MUL, OP_RATIO: w_next = S_MUL;
            OP_DIV:           w_next = S_DIV;
            default:          w_next = S_DONE;
          endcase
        end
      end
      S_ADD: begin
        w_add_x   = {{WIDTH{1'b0}}, r_a};
        w_add_y   = {{WIDTH{1'b0}}, r_b};
        w_add_sub = (r_op == OP_SUB);
        w_next    = w_ratio ? S_DIV : S_DONE;
      end
      S_MUL: begin
        w_add_x = r_acc;
        w_add_y = r_mcand;
        if (w_last_mul) w_next = w_ratio ? S_ADD : S_DONE;
      end
      S_DIV: begin
        w_add_x   = w_div_x;
        w_add_y   = r_dvs;
        w_add_sub = 1'b1;
        if (w_div_zero || w_last_div) w_next = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cmd_ready <= (w_next == S_IDLE);
      r_rsp_valid <= (w_next == S_DONE);
      r_busy      <= (w_next != S_IDLE);
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state == S_MUL || r_state == S_DIV) r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_res    <= '0;
      r_resid  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= cmd_op;
            r_a      <= cmd_a;
            r_b      <= cmd_b;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, cmd_a};
            r_mplier <= cmd_b;
            r_rem    <= '0;
            r_quo    <= {{WIDTH{1'b0}}, cmd_a};
            r_dvs    <= {{WIDTH{1'b0}}, cmd_b};
            // Illegal opcodes go straight to DONE, so the response is set here.
            if (cmd_op > OP_RATIO) begin
              r_res   <= '0;
              r_resid <= '0;
              r_err   <= 1'b1;
            end
          end
        end
        S_ADD: begin
          if (w_ratio) begin
            // Product becomes the dividend, a+b the divisor.
            r_quo <= r_acc;
            r_dvs <= w_sum[RW-1:0];
            r_rem <= '0;
          end else begin
            r_res   <= w_sum[RW-1:0];
            r_resid <= '0;
            r_err   <= 1'b0;
          end
        end
        S_MUL: begin
          r_acc    <= w_mul_acc;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (w_last_mul && !w_ratio) begin
            r_res   <= w_mul_acc;
            r_resid <= '0;
            r_err   <= 1'b0;
          end
        end
        S_DIV: begin
          if (w_div_zero) begin
            r_res   <= '1;
            r_resid <= r_quo;   // dividend, not yet shifted
            r_err   <= 1'b1;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            if (w_last_div) begin
              r_res   <= w_quo_next;
              r_resid <= w_rem_next;
              r_err   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_res;
  assign rsp_residue = r_resid;
  assign rsp_err     = r_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_calc_op_sequencer.sv
module tb_calc_op_sequencer;

  localparam int W = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [W-1:0]    cmd_a;
  logic [W-1:0]    cmd_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [2*W-1:0]  rsp_result;
  logic [2*W-1:0]  rsp_residue;
  logic            rsp_err;
  logic            busy;

  int n_chk = 0;
  int n_err = 0;

  calc_op_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_residue (rsp_residue),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    int             lat;
    logic [2*W-1:0] res;
    logic [2*W-1:0] resid;
    logic           err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command; returns the cycle count k such that rsp_valid is first
  // seen high at T+k (T = accepting edge). Gives up after 40 cycles.
  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int lat);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_a     = W'($urandom);
    cmd_b     = W'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{3'd0, 6'd63, 6'd63,  2, 12'd126,  12'd0, 1'b0};
    vecs[1]  = '{3'd1, 6'd3,  6'd5,   2, 12'hFFE,  12'd0, 1'b0};
    vecs[2]  = '{3'd2, 6'd63, 6'd63,  7, 12'd3969, 12'd0, 1'b0};
    vecs[3]  = '{3'd3, 6'd50, 6'd7,  13, 12'd7,    12'd1, 1'b0};
    vecs[4]  = '{3'd3, 6'd9,  6'd0,   2, 12'hFFF,  12'd9, 1'b1};
    vecs[5]  = '{3'd4, 6'd12, 6'd4,  20, 12'd3,    12'd0, 1'b0};
    vecs[6]  = '{3'd4, 6'd5,  6'd3,  20, 12'd1,    12'd7, 1'b0};
    vecs[7]  = '{3'd4, 6'd0,  6'd0,   9, 12'hFFF,  12'd0, 1'b1};
    vecs[8]  = '{3'd7, 6'd5,  6'd5,   1, 12'd0,    12'd0, 1'b1};
    vecs[9]  = '{3'd5, 6'd1,  6'd2,   1, 12'd0,    12'd0, 1'b1};
    vecs[10] = '{3'd2, 6'd0,  6'd37,  7, 12'd0,    12'd0, 1'b0};
    vecs[11] = '{3'd3, 6'd5,  6'd9,  13, 12'd0,    12'd5, 1'b0};
    vecs[12] = '{3'd4, 6'd63, 6'd63, 20, 12'd31,   12'd63, 1'b0};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result",    32'(rsp_result), 32'd0);
    chk("rst_residue",   32'(rsp_residue), 32'd0);
    chk("rst_err",       32'(rsp_err), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cmd_ready_before_first_edge", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("cmd_ready_after_first_edge", 32'(cmd_ready), 32'd1);

    // Table-driven vectors, rsp_ready held high
    for (int i = 0; i < 13; i++) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_result", i),  32'(rsp_result), 32'(vecs[i].res));
      chk($sformatf("v%0d_residue", i), 32'(rsp_residue), 32'(vecs[i].resid));
      chk($sformatf("v%0d_err", i),     32'(rsp_err), 32'(vecs[i].err));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid_drop", i), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d_ready_back", i), 32'(cmd_ready), 32'd1);
    end

    // Backpressure: MUL 7*9 held in DONE while a new command waits
    rsp_ready = 1'b0;
    run_cmd(3'd2, 6'd7, 6'd9, lat);
    chk("bp_latency", 32'(lat), 32'd7);
    chk("bp_result",  32'(rsp_result), 32'd63);
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_a     = 6'd1;
    cmd_b     = 6'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", i),  32'(rsp_valid), 32'd1);
      chk($sformatf("bp_hold%0d_result", i), 32'(rsp_result), 32'd63);
      chk($sformatf("bp_hold%0d_ready", i),  32'(cmd_ready), 32'd0);
      chk($sformatf("bp_hold%0d_busy", i),   32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    chk("bp_release_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_next_accepted", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_next_latency", 32'(lat), 32'd2);
    chk("bp_next_result",  32'(rsp_result), 32'd3);
    @(posedge clk); #1;

    // Reset in the middle of a DIV
    chk("mid_ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 3'd3;
    cmd_a     = 6'd50;
    cmd_b     = 6'd7;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("mid_busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_result",    32'(rsp_result), 32'd0);
    chk("mid_rst_residue",   32'(rsp_residue), 32'd0);
    chk("mid_rst_err",       32'(rsp_err), 32'd0);
    chk("mid_rst_busy",      32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("mid_no_response_after_reset", 32'(seen), 32'd0);
    run_cmd(3'd0, 6'd1, 6'd1, lat);
    chk("post_reset_add_latency", 32'(lat), 32'd2);
    chk("post_reset_add_result",  32'(rsp_result), 32'd2);
    chk("post_reset_add_err",     32'(rsp_err), 32'd0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
